// File: rtl/xcel_mem_responder.sv
// Word-addressed memory responder with val/rdy request and response ports.
// Responses come back in order after a fixed latency; credit-limited so the response FIFO never overflows.
module xcel_mem_responder #(
   parameter int NUM_WORDS = 256,
   parameter int LATENCY   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memreq_val,
   output logic        memreq_rdy,
   input  logic        memreq_type,
   input  logic [15:0] memreq_addr,
   input  logic [31:0] memreq_wdata,
   output logic        memresp_val,
   input  logic        memresp_rdy,
   output logic        memresp_type,
   output logic [31:0] memresp_data,
   output logic        memresp_err
);

   localparam int MAX   = LATENCY + 1;
   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int PTR_W = $clog2(MAX);
   localparam int CNT_W = $clog2(MAX + 1);
   localparam logic [14:0] NUM_WORDS_C = 15'(NUM_WORDS);

   typedef struct packed {
      logic        typ;
      logic        err;
      logic [31:0] data;
   } resp_t;

   logic [31:0] storage [NUM_WORDS];

   logic [13:0] word_idx;
   logic        req_err;
   logic        req_fire;
   logic        resp_fire;
   logic        wr_en;
   resp_t       req_resp;

   logic        push_val;
   resp_t       push_resp;

   resp_t              fifo_q [MAX];
   resp_t              fifo_d [MAX];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   resp_t              head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX - 1)) ? '0 : p + 1'b1;
   endfunction

   // Read data is sampled here, in the acceptance cycle, so later writes cannot alter it.
   always_comb begin
      word_idx      = memreq_addr[15:2];
      req_err       = (memreq_addr[1:0] != 2'b00) || ({1'b0, word_idx} >= NUM_WORDS_C);
      req_fire      = memreq_val && memreq_rdy;
      resp_fire     = memresp_val && memresp_rdy;
      wr_en         = req_fire && memreq_type && !req_err;
      req_resp.typ  = memreq_type;
      req_resp.err  = req_err;
      req_resp.data = (!memreq_type && !req_err) ? storage[word_idx[IDX_W-1:0]] : 32'd0;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         storage[word_idx[IDX_W-1:0]] <= memreq_wdata;
      end
   end

   generate
      if (LATENCY == 1) begin : g_nopipe
         assign push_val  = req_fire;
         assign push_resp = req_resp;
      end else begin : g_pipe
         logic [LATENCY-2:0] pv_q, pv_d;
         resp_t              pp_q [LATENCY-1];
         resp_t              pp_d [LATENCY-1];

         always_comb begin
            pv_d    = '0;
            pv_d[0] = req_fire;
            pp_d[0] = req_resp;
            for (int i = 1; i < LATENCY - 1; i++) begin
               pv_d[i] = pv_q[i-1];
               pp_d[i] = pp_q[i-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               pv_q <= '0;
            end else begin
               pv_q <= pv_d;
            end
         end

         always_ff @(posedge clk) begin
            pp_q <= pp_d;
         end

         assign push_val  = pv_q[LATENCY-2];
         assign push_resp = pp_q[LATENCY-2];
      end
   endgenerate

   always_comb begin
      fifo_d        = fifo_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      if (push_val) begin
         fifo_d[wr_ptr_q] = push_resp;
         wr_ptr_d         = ptr_inc(wr_ptr_q);
      end
      if (resp_fire) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      fifo_cnt_d    = fifo_cnt_q + CNT_W'(push_val) - CNT_W'(resp_fire);
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_fire);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fifo_cnt_q    <= '0;
         outstanding_q <= '0;
         for (int i = 0; i < MAX; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         fifo_cnt_q    <= fifo_cnt_d;
         outstanding_q <= outstanding_d;
         fifo_q        <= fifo_d;
      end
   end

   // Outputs are gated by valid so stale FIFO slots never leak out when empty.
   always_comb begin
      head         = fifo_q[rd_ptr_q];
      memreq_rdy   = !rst && (outstanding_q < CNT_W'(MAX));
      memresp_val  = (fifo_cnt_q != '0);
      memresp_type = memresp_val && head.typ;
      memresp_err  = memresp_val && head.err;
      memresp_data = memresp_val ? head.data : 32'd0;
   end

endmodule

// File: tb/tb_xcel_mem_responder.sv
// Scoreboard bench for xcel_mem_responder; runs a LATENCY=1 and a LATENCY=4 instance side by side.
// Each instance gets directed scenarios plus a randomized phase against a word-array reference model.
module tb_xcel_mem_responder;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      int unsigned acc;
      logic        typ;
      logic        err;
      logic [31:0] data;
   } exp_t;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   for (genvar c = 0; c < 2; c++) begin : g_cfg
      localparam int LAT  = (c == 0) ? 1 : 4;
      localparam int NW   = (c == 0) ? 64 : 256;
      localparam int MAXO = LAT + 1;
      localparam int IW   = $clog2(NW);

      logic        rst = 1'b1;
      logic        memreq_val = 1'b0;
      logic        memreq_type = 1'b0;
      logic [15:0] memreq_addr = '0;
      logic [31:0] memreq_wdata = '0;
      logic        memreq_rdy;
      logic        memresp_val;
      logic        memresp_rdy = 1'b0;
      logic        memresp_type;
      logic [31:0] memresp_data;
      logic        memresp_err;
      logic        rdy_random = 1'b0;
      logic        rdy_fixed = 1'b1;
      logic        fin = 1'b0;

      logic [31:0] model [NW];
      exp_t        sb [$];

      xcel_mem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
         .clk          (clk),
         .rst          (rst),
         .memreq_val   (memreq_val),
         .memreq_rdy   (memreq_rdy),
         .memreq_type  (memreq_type),
         .memreq_addr  (memreq_addr),
         .memreq_wdata (memreq_wdata),
         .memresp_val  (memresp_val),
         .memresp_rdy  (memresp_rdy),
         .memresp_type (memresp_type),
         .memresp_data (memresp_data),
         .memresp_err  (memresp_err)
      );

      // Consumer side: fixed or randomly toggling ready.
      initial forever begin
         @(posedge clk);
         #2;
         memresp_rdy = rdy_random ? ($urandom_range(0, 9) < 7) : rdy_fixed;
      end

      // Monitor: every cycle compares ready/valid and the FIFO head against the scoreboard.
      initial begin : monitor
         int unsigned outst;
         logic        exp_val;
         forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
               outst = sb.size();
               if (outst > 0 && sb[$].acc == cyc) outst--;
               checkOutput($sformatf("L%0d memreq_rdy", LAT), {31'd0, memreq_rdy}, {31'd0, (outst < MAXO)});
               exp_val = (sb.size() > 0) && (sb[0].acc + LAT <= cyc);
               checkOutput($sformatf("L%0d memresp_val", LAT), {31'd0, memresp_val}, {31'd0, exp_val});
               if (exp_val && memresp_val) begin
                  checkOutput($sformatf("L%0d memresp_type", LAT), {31'd0, memresp_type}, {31'd0, sb[0].typ});
                  checkOutput($sformatf("L%0d memresp_err", LAT), {31'd0, memresp_err}, {31'd0, sb[0].err});
                  checkOutput($sformatf("L%0d memresp_data", LAT), memresp_data, sb[0].data);
                  if (memresp_rdy) void'(sb.pop_front());
               end
            end
         end
      end

      // Drives one request and holds it until accepted; the expected response is queued at acceptance.
      task automatic applyStimulus(input logic typ, input logic [15:0] addr, input logic [31:0] wd);
         int   waited;
         logic accepted;
         logic err;
         exp_t e;
         waited       = 0;
         accepted     = 1'b0;
         memreq_val   = 1'b1;
         memreq_type  = typ;
         memreq_addr  = addr;
         memreq_wdata = wd;
         while (!accepted && waited < 50) begin
            @(negedge clk);
            if (memreq_rdy) begin
               accepted = 1'b1;
               err      = (addr[1:0] != 2'b00) || (int'(addr[15:2]) >= NW);
               e.acc    = cyc;
               e.typ    = typ;
               e.err    = err;
               e.data   = (!typ && !err) ? model[addr[IW+1:2]] : 32'd0;
               if (typ && !err) model[addr[IW+1:2]] = wd;
               sb.push_back(e);
            end else begin
               waited++;
            end
            @(posedge clk);
            #1;
         end
         if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL L%0d req_accept_timeout: got no accept, expected accept of addr 0x%0h", LAT, addr);
         end
      endtask

      task automatic idleReq();
         memreq_val  = 1'b0;
         memreq_type = 1'b0;
      endtask

      task automatic drain();
         int n;
         n = 0;
         while (sb.size() > 0 && n < 300) begin
            tick(1);
            n++;
         end
         checkOutput($sformatf("L%0d drain_pending", LAT), sb.size(), 0);
      endtask

      task automatic checkIdleOutputs(input string tag);
         checkOutput($sformatf("L%0d %s rdy", LAT, tag), {31'd0, memreq_rdy}, 32'd1);
         checkOutput($sformatf("L%0d %s val", LAT, tag), {31'd0, memresp_val}, 32'd0);
         checkOutput($sformatf("L%0d %s type", LAT, tag), {31'd0, memresp_type}, 32'd0);
         checkOutput($sformatf("L%0d %s data", LAT, tag), memresp_data, 32'd0);
         checkOutput($sformatf("L%0d %s err", LAT, tag), {31'd0, memresp_err}, 32'd0);
      endtask

      initial begin : stim
         logic [15:0] a;
         tick(2);
         rst = 1'b0;
         @(negedge clk);
         checkIdleOutputs("post_reset");
         @(posedge clk);
         #1;

         for (int i = 0; i < NW; i++) applyStimulus(1'b1, 16'(i * 4), $urandom);

         applyStimulus(1'b1, 16'h0008, 32'hDEADBEEF);
         applyStimulus(1'b0, 16'h0008, 32'd0);

         applyStimulus(1'b0, 16'h0002, 32'd0);
         applyStimulus(1'b0, 16'(NW * 4), 32'd0);
         applyStimulus(1'b1, 16'h0006, 32'd5);
         applyStimulus(1'b0, 16'h0004, 32'd0);

         applyStimulus(1'b1, 16'h0010, 32'd7);
         applyStimulus(1'b0, 16'h0010, 32'd0);
         applyStimulus(1'b1, 16'h0010, 32'd9);
         applyStimulus(1'b0, 16'h0010, 32'd0);

         for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'(i * 4), 32'(i + 1));
         for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'(i * 4), 32'd0);
         idleReq();
         drain();

         rdy_fixed = 1'b0;
         for (int i = 0; i < MAXO; i++) applyStimulus(1'b0, 16'(i * 4), 32'd0);
         idleReq();
         @(negedge clk);
         checkOutput($sformatf("L%0d bp_rdy_low", LAT), {31'd0, memreq_rdy}, 32'd0);
         @(posedge clk);
         #1;
         tick(2);
         rdy_fixed = 1'b1;
         applyStimulus(1'b0, 16'h001C, 32'd0);
         idleReq();
         drain();

         rdy_random = 1'b1;
         repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
               idleReq();
               tick(1);
            end else begin
               if ($urandom_range(0, 9) < 7) a = 16'($urandom_range(0, NW - 1) * 4);
               else a = 16'($urandom);
               applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
            end
         end
         idleReq();
         rdy_random = 1'b0;
         rdy_fixed  = 1'b1;
         drain();

         // Mid-flight reset with a write presented while rst is high.
         rdy_fixed = 1'b0;
         tick(1);
         applyStimulus(1'b0, 16'h0000, 32'd0);
         applyStimulus(1'b0, 16'h0004, 32'd0);
         rst          = 1'b1;
         memreq_val   = 1'b1;
         memreq_type  = 1'b1;
         memreq_addr  = 16'h0020;
         memreq_wdata = 32'h12345678;
         @(negedge clk);
         sb.delete();
         checkOutput($sformatf("L%0d rst_rdy_low", LAT), {31'd0, memreq_rdy}, 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         idleReq();
         rdy_fixed = 1'b1;
         @(negedge clk);
         checkIdleOutputs("mid_reset");
         @(posedge clk);
         #1;
         tick(LAT + 3);
         applyStimulus(1'b0, 16'h0020, 32'd0);
         applyStimulus(1'b0, 16'h0000, 32'd0);
         idleReq();
         drain();
         fin = 1'b1;
      end
   end

   initial begin : finisher
      int w;
      w = 0;
      while (!(g_cfg[0].fin && g_cfg[1].fin) && w < 60000) begin
         @(posedge clk);
         w++;
      end
      if (!(g_cfg[0].fin && g_cfg[1].fin)) begin
         checks++;
         errors++;
         $display("[TB] FAIL global_timeout: got unfinished stimulus after %0d cycles, expected completion", w);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
